// File: rtl/conv_fmap_collector.sv
// Output sink of the 3x3 convolution engine: drops wrap-around columns, applies ReLU plus requantise,
// buffers one OUT_H x OUT_W feature map and drains it in raster order over valid/ready.
module conv_fmap_collector #(
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned K      = 3,
    parameter int unsigned OUT_W  = IMG_W - K + 1,
    parameter int unsigned OUT_H  = 26,
    parameter int unsigned SHIFT  = 12,
    parameter int unsigned DW_IN  = 32,
    parameter int unsigned DW_OUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DW_IN-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW_OUT-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NPIX = OUT_W * OUT_H;
    localparam int unsigned AW   = $clog2(NPIX + 1);
    localparam int unsigned CW   = $clog2(IMG_W);
    localparam int unsigned RW   = $clog2(OUT_H);

    localparam logic [CW-1:0] ColMax   = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ColKeep  = CW'(OUT_W);
    localparam logic [CW-1:0] ColEnd   = CW'(OUT_W - 1);
    localparam logic [RW-1:0] RowEnd   = RW'(OUT_H - 1);
    localparam logic [AW-1:0] AddrLast = AW'(NPIX - 1);
    localparam logic [AW-1:0] AddrEnd  = AW'(NPIX);
    localparam logic signed [DW_IN-1:0] SatMax = DW_IN'((1 << (DW_OUT - 1)) - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

    state_e state_q, state_d;

    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [AW-1:0]     waddr_q;
    logic [AW-1:0]     raddr_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [DW_OUT-1:0] out_data_q;
    logic              done_q;

    logic [DW_OUT-1:0] mem [NPIX];

    logic                    accept;
    logic                    keep;
    logic                    frame_end;
    logic                    advance;
    logic                    last_hs;
    logic signed [DW_IN-1:0] shifted;
    logic [DW_OUT-1:0]       quant;

    always_comb begin
        accept    = (state_q == StCollect) && in_valid;
        keep      = accept && (col_q < ColKeep);
        frame_end = accept && (row_q == RowEnd) && (col_q == ColEnd);
        // Output register may load whenever it is empty or being consumed this cycle.
        advance   = !out_valid_q || out_ready;
        last_hs   = out_valid_q && out_ready && out_last_q;
    end

    always_comb begin
        shifted = $signed(in_data) >>> SHIFT;
        if (in_data[DW_IN-1]) begin
            quant = '0;
        end else if (shifted > SatMax) begin
            quant = SatMax[DW_OUT-1:0];
        end else begin
            quant = shifted[DW_OUT-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start)     state_d = StCollect;
            StCollect: if (frame_end) state_d = StDrain;
            StDrain:   if (last_hs)   state_d = StIdle;
            default:                  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            waddr_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            col_q   <= '0;
            row_q   <= '0;
            waddr_q <= '0;
        end else if (accept) begin
            if (col_q == ColMax) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
            if (keep) begin
                waddr_q <= waddr_q + 1'b1;
            end
        end
    end

    // Stored samples are packed densely, so the write address is a plain running count.
    always_ff @(posedge clk) begin
        if (keep) begin
            mem[waddr_q] <= quant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= last_hs;
            if (state_q != StDrain) begin
                raddr_q     <= '0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else if (advance) begin
                if (raddr_q != AddrEnd) begin
                    out_data_q  <= mem[raddr_q];
                    out_valid_q <= 1'b1;
                    out_last_q  <= (raddr_q == AddrLast);
                    raddr_q     <= raddr_q + 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_conv_fmap_collector.sv
// Scoreboard bench for conv_fmap_collector: stimulus pushes expected beats, a negedge monitor
// pops and compares every output handshake and checks hold-stability under backpressure.
module tb_conv_fmap_collector;

    localparam int IMG_W = 28;
    localparam int OUT_W = 26;
    localparam int OUT_H = 26;
    localparam int NPIX  = OUT_W * OUT_H;
    localparam int NSAMP = (OUT_H - 1) * IMG_W + OUT_W;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    conv_fmap_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [16:0] sb[$];  // {last, data}
    int beats = 0;
    int done_cnt = 0;
    int last_cnt = 0;
    int beat_base = 0;
    bit bp_mode = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sample_val(input int mode, input int n);
        logic [31:0] arith [5];
        arith[0] = -32'sd5000;
        arith[1] = 32'd4095;
        arith[2] = 32'd4096;
        arith[3] = 32'd134213632;
        arith[4] = 32'h7FFF_FFFF;
        if (mode == 0) return 32'(n) << 12;
        if (n < 5) return arith[n];
        return 32'd0;
    endfunction

    function automatic logic [15:0] expect_val(input int mode, input int n);
        logic [15:0] arith [5];
        arith[0] = 16'd0;
        arith[1] = 16'd0;
        arith[2] = 16'd1;
        arith[3] = 16'd32767;
        arith[4] = 16'd32767;
        if (mode == 0) return 16'(n);
        if (n < 5) return arith[n];
        return 16'd0;
    endfunction

    // Monitor: one negedge view of each cycle's handshake.
    initial begin
        logic        stall_prev;
        logic [15:0] held_data;
        logic        held_last;
        logic [16:0] e;
        stall_prev = 1'b0;
        held_data  = '0;
        held_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                continue;
            end
            if (done) done_cnt++;
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held_data);
                check("hold_last", out_last, held_last);
            end
            if (out_valid && out_ready) begin
                beats++;
                if (out_last) last_cnt++;
                if (sb.size() == 0) begin
                    check("extra_beat_queue_size", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("data_beat%0d", beats - beat_base), out_data, e[15:0]);
                    check($sformatf("last_beat%0d", beats - beat_base), out_last, e[16]);
                end
            end
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
        end
    end

    // Ready driver: always 1, or 5-cycle stall at beat 10 then 1010 toggling.
    initial begin
        int  stall_left;
        bit  tog;
        stall_left = 5;
        tog        = 1'b1;
        out_ready  = 1'b1;
        forever begin
            tick();
            if (!bp_mode) begin
                out_ready  = 1'b1;
                stall_left = 5;
                tog        = 1'b1;
            end else if (beats - beat_base < 10) begin
                out_ready = 1'b1;
            end else if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = tog;
                tog       = !tog;
            end
        end
    end

    task automatic run_frame(input int mode, input int gap, input bit bp, input bit sdrain);
        int  d0;
        int  l0;
        int  k;
        bit  seen;
        d0        = done_cnt;
        l0        = last_cnt;
        beat_base = beats;
        bp_mode   = bp;
        // Sample presented in the start cycle must be ignored.
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h7FFF_FFFF;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check("busy_after_start", busy, 1);
        k = 0;
        for (int n = 0; n < NSAMP; n++) begin
            while ($urandom_range(99) < gap) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                tick();
            end
            in_valid = 1'b1;
            in_data  = sample_val(mode, n);
            if ((n % IMG_W) < OUT_W) begin
                sb.push_back({(k == NPIX - 1), expect_val(mode, n)});
                k++;
            end
            tick();
        end
        // Surplus samples after the frame end must not be stored.
        in_data = 32'h7FFF_FFFF;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        if (sdrain) begin
            tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        seen = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", seen, 1);
        @(negedge clk);
        @(negedge clk);
        bp_mode = 1'b0;
        check("done_pulses", done_cnt - d0, 1);
        check("last_count", last_cnt - l0, 1);
        check("beat_count", beats - beat_base, NPIX);
        check("queue_empty", sb.size(), 0);
        check("busy_idle", busy, 0);
        check("valid_idle", out_valid, 0);
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        tick();
        // in_valid in IDLE is ignored.
        in_valid = 1'b1;
        in_data  = 32'h0123_4567;
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);

        run_frame(0, 0, 1'b0, 1'b0);   // ramp
        run_frame(1, 0, 1'b0, 1'b0);   // arithmetic
        run_frame(0, 0, 1'b1, 1'b0);   // backpressure
        run_frame(0, 30, 1'b0, 1'b0);  // input gaps

        // Reset mid-collect.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 300; n++) begin
            in_valid = 1'b1;
            in_data  = 32'h0FFF_0000;
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_last", out_last, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst_busy", busy, 0);
        run_frame(0, 0, 1'b0, 1'b0);

        run_frame(0, 0, 1'b0, 1'b1);   // start during drain ignored
        run_frame(1, 0, 1'b0, 1'b0);   // another frame after done

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_fmap_collector.md
Name: conv_fmap_collector

Overview:
- Sink for the 3x3 convolution engine's output stream.
- Takes the engine's raw 32-bit signed result per cycle and discards the wrap-around positions.
- Applies ReLU and requantises to 16 bits, then stores the valid OUT_H x OUT_W feature map in an internal buffer.
- After a full frame, drains the map in raster order over a valid/ready stream to the next layer (pooling).

Parameters:
- IMG_W, 28, input image width in pixels (row stride of the convolution output stream).
- K, 3, kernel size.
- OUT_W, IMG_W-K+1 (26), valid output columns per row.
- OUT_H, 26, valid output rows per frame.
- SHIFT, 12, arithmetic right shift applied after ReLU.
- DW_IN, 32, input sample width (signed).
- DW_OUT, 16, output sample width (signed, non-negative after ReLU).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; arms collection of one frame.
- in_valid  input  1  qualifies in_data for one cycle.
- in_data  input  DW_IN  signed convolution result.
- out_valid  output  1  out_data holds a feature-map sample.
- out_ready  input  1  downstream accepts the sample when high with out_valid.
- out_data  output  DW_OUT  requantised sample.
- out_last  output  1  high with the final sample (index OUT_H*OUT_W-1).
- busy  output  1  high in COLLECT or DRAIN.
- done  output  1  one-cycle pulse after the last output handshake.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - out_valid, out_data, out_last, busy, done = 0.
  - Column counter, row counter and read address = 0.
  - Buffer contents undefined.
- State IDLE:
  - in_valid ignored.
  - start -> COLLECT; column and row counters cleared. A sample arriving in the start cycle is not captured.
- State COLLECT:
  - Each in_valid advances col 0..IMG_W-1.
  - col wrap advances row.
  - Sample stored only when col < OUT_W, at address row*OUT_W+col.
  - Columns OUT_W..IMG_W-1 are wrap-around windows and are dropped.
  - Gaps in in_valid are allowed; position advances only on valid cycles.
  - Accepting row=OUT_H-1, col=OUT_W-1 -> DRAIN next cycle; later in_valid ignored.
- Requantise, applied on write:
  - x<0 -> 0.
  - Otherwise y = x >>> SHIFT.
  - y > 2^(DW_OUT-1)-1 saturates to 32767.
- State DRAIN:
  - Buffer read in addresses 0..OUT_H*OUT_W-1 (0..675).
  - Buffer read latency is 1 cycle; first out_valid no later than 2 cycles after DRAIN entry.
  - out_data, out_valid and out_last are registered.
  - While out_valid=1 and out_ready=0, all three hold stable.
  - A new sample is presented the cycle after each handshake, or the same sequence is kept bubble-free when out_ready stays high (1 beat/cycle sustained).
  - No beat is lost or duplicated.
  - out_last=1 only with address 675.
  - Handshake on last beat: next cycle out_valid=0, done=1 for exactly one cycle, state IDLE, busy=0.
- start while busy=1 is ignored.
- Reset mid-operation aborts immediately to IDLE; the next start collects a fresh frame correctly.
- busy asserts the cycle after start is accepted.

Test Plan:
- Ramp: start, then 726 consecutive in_valid with in_data = n<<12 (n=0..725), out_ready=1 -> exactly 676 beats.
  - out[0]=0, out[25]=25, out[26]=28, out[675]=725.
  - out_last only on beat 676; done pulse once.
- Arithmetic: inputs at frame position 0 of -5000, 4095, 4096, 134213632, 0x7FFFFFFF -> outputs 0, 0, 1, 32767, 32767 respectively (one per frame, or placed at distinct valid positions).
- Backpressure: ramp frame with out_ready low 5 cycles at beat 10 and toggling 1010 thereafter.
  - out_data stable while stalled.
  - Full sequence 0..725 (skipping dropped columns) intact.
- Input gaps: ramp frame with in_valid deasserted randomly 30% of cycles -> identical output sequence to the ramp test.
- Reset mid-collect: rst_n low for 2 cycles after 300 samples -> all outputs 0, busy=0. A following start plus ramp frame reproduces the ramp result.
- Ignored events:
  - start pulsed during DRAIN -> no restart; sequence continues.
  - in_valid during IDLE and after the last needed sample -> not stored.
  - A second frame after done gives the correct result.
